// File: rtl/otp_bank_mixer_if.sv
// Stream, write-port and status bundle of otp_bank_mixer.
// The slave side is the mixer. The master side is the SD controller, the OTP
// generator and the stream consumer seen as one agent.
interface otp_bank_mixer_if #(
  parameter int BANKS  = 8,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 1024
);
  localparam int BANK_W = $clog2(BANKS);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              iraw_we;
  logic [BANK_W-1:0] iraw_bank;
  logic [ADDR_W-1:0] iraw_addr;
  logic [DATA_W-1:0] iraw_data;
  logic              iotp_we;
  logic [BANK_W-1:0] iotp_bank;
  logic [ADDR_W-1:0] iotp_addr;
  logic [DATA_W-1:0] iotp_data;
  logic              iotp_last;
  logic              imode;
  logic              istart;
  logic [BANK_W-1:0] istart_bank;
  logic              iready;
  logic [DATA_W-1:0] odata;
  logic              ovalid;
  logic              olast;
  logic              obusy;
  logic              odone;
  logic              oerr;
  logic [BANKS-1:0]  ootp_valid;

  modport slave (
    input  iraw_we, iraw_bank, iraw_addr, iraw_data,
    input  iotp_we, iotp_bank, iotp_addr, iotp_data, iotp_last,
    input  imode, istart, istart_bank, iready,
    output odata, ovalid, olast, obusy, odone, oerr, ootp_valid
  );

  modport master (
    output iraw_we, iraw_bank, iraw_addr, iraw_data,
    output iotp_we, iotp_bank, iotp_addr, iotp_data, iotp_last,
    output imode, istart, istart_bank, iready,
    input  odata, ovalid, olast, obusy, odone, oerr, ootp_valid
  );
endinterface

// File: rtl/otp_bank_mixer.sv
// Banked raw/pad RAM pairs streamed out as raw ^ pad (or raw only in bypass).
// Each pad is marked fresh when its last word is written and retired after it
// has been streamed, so a pad is never applied twice.
//
// state  | meaning
// IDLE   | waiting for istart; bad XOR requests get an oerr pulse
// STREAM | issuing reads 0..DEPTH-1 whenever the output stage has room
// DRAIN  | all reads issued; waiting for the olast word to be accepted
module otp_bank_mixer #(
  parameter int BANKS  = 8,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 1024
) (
  input  logic iclk,
  input  logic irst,
  otp_bank_mixer_if.slave bus
);
  localparam int BANK_W = $clog2(BANKS);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [BANK_W-1:0] cur_bank;
  logic              cur_mode;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] out_cnt;
  logic [DATA_W-1:0] raw_q, pad_q, sk_data;
  logic              q_vld, sk_vld;
  logic              oerr_q, odone_q;
  logic [BANKS-1:0]  otp_vld_q;

  logic [DATA_W-1:0] raw_mem [BANKS][DEPTH];
  logic [DATA_W-1:0] pad_mem [BANKS][DEPTH];

  logic              busy, issue, start_ok, err_d, done_d;
  logic              ovalid, pop, head_last, sk_keep, q_keep;
  logic              raw_ok, otp_ok;
  logic [DATA_W-1:0] q_mix;

  // The output stage is the RAM read register (q) plus one skid entry holding
  // the older word; the head is the skid entry when present.
  assign busy      = (state_q != S_IDLE);
  assign q_mix     = cur_mode ? raw_q : (raw_q ^ pad_q);
  assign ovalid    = sk_vld | q_vld;
  assign pop       = ovalid & bus.iready;
  assign head_last = (out_cnt == LAST_ADDR);
  assign sk_keep   = sk_vld & ~pop;
  assign q_keep    = q_vld & ~(pop & ~sk_vld);
  assign raw_ok    = bus.iraw_we & ~(busy & (bus.iraw_bank == cur_bank));
  assign otp_ok    = bus.iotp_we & ~(busy & (bus.iotp_bank == cur_bank));

  assign bus.ovalid     = ovalid;
  assign bus.odata      = ovalid ? (sk_vld ? sk_data : q_mix) : '0;
  assign bus.olast      = ovalid & head_last;
  assign bus.obusy      = busy;
  assign bus.odone      = odone_q;
  assign bus.oerr       = oerr_q;
  assign bus.ootp_valid = otp_vld_q;

  // Next state, read issue and start/done/error decisions.
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    start_ok = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.istart) begin
          if (!bus.imode && !otp_vld_q[bus.istart_bank]) begin
            err_d = 1'b1;
          end else begin
            start_ok = 1'b1;
            state_d  = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        // A new read would overwrite q; only blocked when both slots stay full.
        issue = ~(sk_keep & q_keep);
        if (issue && rd_addr == LAST_ADDR) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && head_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, stream counters, output stage and pad freshness flags.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q   <= S_IDLE;
      cur_bank  <= '0;
      cur_mode  <= 1'b0;
      rd_addr   <= '0;
      out_cnt   <= '0;
      q_vld     <= 1'b0;
      sk_vld    <= 1'b0;
      sk_data   <= '0;
      oerr_q    <= 1'b0;
      odone_q   <= 1'b0;
      otp_vld_q <= '0;
    end else begin
      state_q <= state_d;
      oerr_q  <= err_d;
      odone_q <= done_d;
      if (start_ok) begin
        cur_bank <= bus.istart_bank;
        cur_mode <= bus.imode;
        rd_addr  <= '0;
        out_cnt  <= '0;
      end else begin
        if (issue) rd_addr <= rd_addr + ADDR_W'(1);
        if (pop)   out_cnt <= out_cnt + ADDR_W'(1);
      end
      q_vld  <= issue | (sk_keep & q_keep);
      sk_vld <= sk_keep | q_keep;
      if (!sk_keep && q_keep) sk_data <= q_mix;
      if (otp_ok) otp_vld_q[bus.iotp_bank] <= bus.iotp_last;
      if (done_d && !cur_mode) otp_vld_q[cur_bank] <= 1'b0;
    end
  end

  // RAM arrays: writes to the bank being streamed are dropped; no reset.
  always_ff @(posedge iclk) begin
    if (raw_ok) raw_mem[bus.iraw_bank][bus.iraw_addr] <= bus.iraw_data;
    if (otp_ok) pad_mem[bus.iotp_bank][bus.iotp_addr] <= bus.iotp_data;
    if (issue) begin
      raw_q <= raw_mem[cur_bank][rd_addr];
      pad_q <= pad_mem[cur_bank][rd_addr];
    end
  end
endmodule

// File: tb/tb_otp_bank_mixer.sv
module tb_otp_bank_mixer;
  localparam int BANKS  = 8;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 1024;
  localparam int BANK_W = $clog2(BANKS);
  localparam int ADDR_W = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  otp_bank_mixer_if #(.BANKS(BANKS), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  otp_bank_mixer #(.BANKS(BANKS), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .iclk (clk),
    .irst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] mraw [BANKS][DEPTH];
  logic [DATA_W-1:0] mpad [BANKS][DEPTH];
  logic [BANKS-1:0]  mflags = '0;
  logic [DATA_W:0]   exp_q [$];

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int last_hs_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on each handshake, stall stability, pulse counts.
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", bus.ovalid, 1'b1);
        check("stall_data", bus.odata, prev_data);
        check("stall_last", bus.olast, prev_last);
      end
      if (bus.ovalid && bus.iready) begin
        check("sb_has_entry", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          logic [DATA_W:0] e;
          e = exp_q.pop_front();
          check("word_data", bus.odata, e[DATA_W-1:0]);
          check("word_last", bus.olast, e[DATA_W]);
          if (bus.olast) last_hs_cyc = cyc;
        end
      end
      if (bus.odone) done_cnt++;
      if (bus.oerr) err_cnt++;
      prev_stall = bus.ovalid & ~bus.iready;
      prev_data  = bus.odata;
      prev_last  = bus.olast;
    end
  end

  task automatic fill(input int bank, input bit rnd, input bit do_raw, input bit do_pad);
    for (int a = 0; a < DEPTH; a++) begin
      logic [DATA_W-1:0] r, p;
      r = rnd ? DATA_W'($urandom) : DATA_W'(a & 15);
      p = rnd ? DATA_W'($urandom) : DATA_W'(4'hA);
      @(posedge clk); #1;
      bus.iraw_we   = do_raw;
      bus.iraw_bank = BANK_W'(bank);
      bus.iraw_addr = ADDR_W'(a);
      bus.iraw_data = r;
      bus.iotp_we   = do_pad;
      bus.iotp_bank = BANK_W'(bank);
      bus.iotp_addr = ADDR_W'(a);
      bus.iotp_data = p;
      bus.iotp_last = (a == DEPTH - 1);
      if (do_raw) mraw[bank][a] = r;
      if (do_pad) mpad[bank][a] = p;
    end
    @(posedge clk); #1;
    bus.iraw_we = 1'b0; bus.iotp_we = 1'b0; bus.iotp_last = 1'b0;
    if (do_pad) mflags[bank] = 1'b1;
    @(negedge clk);
    check("flags_after_fill", bus.ootp_valid, mflags);
  endtask

  task automatic wr_pad(input int bank, input int addr, input logic [DATA_W-1:0] d, input bit last);
    @(posedge clk); #1;
    bus.iotp_we = 1'b1; bus.iotp_bank = BANK_W'(bank); bus.iotp_addr = ADDR_W'(addr);
    bus.iotp_data = d; bus.iotp_last = last;
    @(posedge clk); #1;
    bus.iotp_we = 1'b0; bus.iotp_last = 1'b0;
    mpad[bank][addr] = d;
    mflags[bank] = last;
    @(negedge clk);
    check("flags_after_pad_write", bus.ootp_valid, mflags);
  endtask

  task automatic stream(input int bank, input bit mode, input bit rnd, input bit ok,
                        input bit midwr, input int abort_at);
    int e0, d0, sc, dc;
    bit to;
    if (ok)
      for (int a = 0; a < DEPTH; a++)
        exp_q.push_back({a == DEPTH - 1, mode ? mraw[bank][a] : (mraw[bank][a] ^ mpad[bank][a])});
    e0 = err_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    bus.istart = 1'b1; bus.istart_bank = BANK_W'(bank); bus.imode = mode;
    @(negedge clk); sc = cyc;
    @(posedge clk); #1;
    bus.istart = 1'b0;
    @(negedge clk);
    if (!ok) begin
      check("reject_err_pulse", bus.oerr, 1'b1);
      check("reject_busy", bus.obusy, 1'b0);
      check("reject_valid", bus.ovalid, 1'b0);
      repeat (3) @(negedge clk);
      check("reject_err_count", err_cnt, e0 + 1);
      check("reject_busy_later", bus.obusy, 1'b0);
      return;
    end
    check("start_busy", bus.obusy, 1'b1);
    check("start_no_valid_yet", bus.ovalid, 1'b0);
    check("start_no_err", bus.oerr, 1'b0);
    to = 1'b1; dc = 0;
    for (int n = 0; n < 4 * DEPTH + 100; n++) begin
      @(posedge clk); #1;
      bus.iready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.iotp_we = 1'b0; bus.iraw_we = 1'b0; bus.iotp_last = 1'b0;
      if (midwr && n == 100) begin
        bus.iotp_we = 1'b1; bus.iotp_bank = BANK_W'(2); bus.iotp_addr = ADDR_W'(37);
        bus.iotp_data = ~mpad[2][37]; bus.iotp_last = 1'b1;
      end
      if (midwr && n == 101) begin
        bus.iotp_we = 1'b1; bus.iotp_bank = BANK_W'(5); bus.iotp_addr = ADDR_W'(9);
        bus.iotp_data = 4'h6; bus.iotp_last = 1'b1;
        bus.iraw_we = 1'b1; bus.iraw_bank = BANK_W'(2); bus.iraw_addr = ADDR_W'(37);
        bus.iraw_data = ~mraw[2][37];
        mpad[5][9] = 4'h6;
        mflags[5]  = 1'b1;
      end
      if (abort_at >= 0 && (DEPTH - exp_q.size()) >= abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", bus.ovalid, 1'b0);
        check("abort_busy", bus.obusy, 1'b0);
        check("abort_last", bus.olast, 1'b0);
        check("abort_data", bus.odata, '0);
        check("abort_done", bus.odone, 1'b0);
        check("abort_flags", bus.ootp_valid, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.iready = 1'b1;
        exp_q.delete();
        mflags = '0;
        repeat (5) @(negedge clk);
        check("abort_no_done", done_cnt, d0);
        check("abort_idle", bus.obusy, 1'b0);
        return;
      end
      @(negedge clk);
      if (bus.odone) begin
        to = 1'b0; dc = cyc;
        break;
      end
    end
    bus.iready = 1'b1;
    check("stream_timeout", to, 1'b0);
    if (!rnd) begin
      check("last_hs_latency", last_hs_cyc - sc, DEPTH + 1);
      check("done_latency", dc - sc, DEPTH + 2);
    end
    @(negedge clk);
    check("done_once", done_cnt, d0 + 1);
    check("done_pulse_width", bus.odone, 1'b0);
    check("idle_after_done", bus.obusy, 1'b0);
    check("sb_drained", exp_q.size(), 0);
    check("no_err_on_good_start", err_cnt, e0);
    if (!mode) mflags[bank] = 1'b0;
    check("flags_after_stream", bus.ootp_valid, mflags);
  endtask

  initial begin
    bus.iraw_we = 1'b0; bus.iraw_bank = '0; bus.iraw_addr = '0; bus.iraw_data = '0;
    bus.iotp_we = 1'b0; bus.iotp_bank = '0; bus.iotp_addr = '0; bus.iotp_data = '0;
    bus.iotp_last = 1'b0; bus.imode = 1'b0; bus.istart = 1'b0; bus.istart_bank = '0;
    bus.iready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ovalid", bus.ovalid, 1'b0);
    check("rst_olast", bus.olast, 1'b0);
    check("rst_obusy", bus.obusy, 1'b0);
    check("rst_odone", bus.odone, 1'b0);
    check("rst_oerr", bus.oerr, 1'b0);
    check("rst_odata", bus.odata, '0);
    check("rst_flags", bus.ootp_valid, '0);

    // bank 3: raw = addr[3:0], pad = 4'hA, XOR stream with iready held high
    fill(3, 1'b0, 1'b1, 1'b1);
    stream(3, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    // pad consumed: XOR rejected, bypass still streams raw
    stream(3, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    stream(3, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    // fresh random pad, XOR stream under random backpressure
    fill(3, 1'b1, 1'b0, 1'b1);
    stream(3, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    // bank 2 stream with mid-stream writes to bank 2 (dropped) and bank 5
    fill(2, 1'b1, 1'b1, 1'b1);
    stream(2, 1'b0, 1'b1, 1'b1, 1'b1, -1);
    // overwrite of a fresh pad without last retires it
    wr_pad(5, 0, 4'h3, 1'b0);
    // re-arm bank 2 via its address 0 only; address 37 must still hold the old pad
    wr_pad(2, 0, 4'h9, 1'b1);
    stream(2, 1'b0, 1'b0, 1'b1, 1'b0, 500);
    // after the abort, a fresh fill and stream works
    fill(7, 1'b1, 1'b1, 1'b1);
    stream(7, 1'b0, 1'b0, 1'b1, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
